// File: rtl/serial_bcd_adder_ctrl.sv
// Multi-digit packed-BCD adder: one shared digit add/correct stage, LSD first, one digit per clock.
// Optional invalid-digit flag enabled by defining BCD_INVALID_CHECK_EN; otherwise err_o is tied low.
module serial_bcd_adder_ctrl #(
    parameter int unsigned NDIG = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [4*NDIG-1:0] a_i,
    input  logic [4*NDIG-1:0] b_i,
    input  logic              cin_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [4*NDIG-1:0] sum_o,
    output logic              cout_o,
    output logic              err_o
);

    localparam int unsigned W    = 4 * NDIG;
    localparam int unsigned CntW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NDIG - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q;
    logic [W-1:0]    a_q, b_q, work_q, sum_q;
    logic            carry_q, cout_q, busy_q, done_q;
    logic [CntW-1:0] cnt_q;

    logic [4:0]      z, z_adj;
    logic [3:0]      dig;
    logic            dig_carry;
    logic [W+3:0]    work_cat;
    logic [W-1:0]    work_nxt;

    // Single-digit stage; the new digit enters the work register from the top.
    always_comb begin
        z         = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0, carry_q};
        z_adj     = z + 5'd6;
        dig_carry = (z > 5'd9);
        dig       = dig_carry ? z_adj[3:0] : z[3:0];
        work_cat  = {dig, work_q};
        work_nxt  = work_cat[W+3:4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        carry_q <= cin_i;
                        work_q  <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    a_q     <= a_q >> 4;
                    b_q     <= b_q >> 4;
                    carry_q <= dig_carry;
                    work_q  <= work_nxt;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        sum_q   <= work_nxt;
                        cout_q  <= dig_carry;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef BCD_INVALID_CHECK_EN
    logic inv_q, err_q;

    function automatic logic has_invalid(input logic [W-1:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (v[4*i +: 4] > 4'd9) r = 1'b1;
        end
        return r;
    endfunction

    // Flag is captured at accept but only published alongside the sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_q <= 1'b0;
            err_q <= 1'b0;
        end else if (state_q != StRun) begin
            if (start_i) inv_q <= has_invalid(a_i) | has_invalid(b_i);
        end else if (cnt_q == LastCnt) begin
            err_q <= inv_q;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign sum_o  = sum_q;
    assign cout_o = cout_q;

endmodule

// File: tb/tb_serial_bcd_adder_ctrl.sv
// Bench for serial_bcd_adder_ctrl: directed cases plus random BCD operands checked against
// a decimal-arithmetic reference model.
module tb_serial_bcd_adder_ctrl;

    localparam int unsigned NDIG = 4;
    localparam int unsigned W    = 4 * NDIG;
`ifdef BCD_INVALID_CHECK_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic         clk, rst_n, start, cin_in;
    logic [W-1:0] a_in, b_in;
    logic         busy, done, cout, err;
    logic [W-1:0] sum;

    int           n_total = 0;
    int           n_bad   = 0;
    logic [W-1:0] prev_sum;

    serial_bcd_adder_ctrl #(.NDIG(NDIG)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .a_i     (a_in),
        .b_i     (b_in),
        .cin_i   (cin_in),
        .busy_o  (busy),
        .done_o  (done),
        .sum_o   (sum),
        .cout_o  (cout),
        .err_o   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int unsigned bcd2int(input logic [W-1:0] v);
        int unsigned r = 0;
        for (int i = NDIG - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int unsigned n);
        logic [W-1:0] r = '0;
        for (int i = 0; i < int'(NDIG); i++) begin
            r[4*i +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r = '0;
        for (int i = 0; i < int'(NDIG); i++) r[4*i +: 4] = 4'($urandom_range(9, 0));
        return r;
    endfunction

    function automatic int unsigned pow10n();
        int unsigned p = 1;
        for (int i = 0; i < int'(NDIG); i++) p = p * 10;
        return p;
    endfunction

    // Called at a negedge with the DUT idle or in its done cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic [W-1:0] es, input logic ec, input logic ee,
                          input bit noise);
        start  = 1'b1;
        a_in   = a;
        b_in   = b;
        cin_in = cin;
        @(posedge clk);
        for (int j = 1; j <= int'(NDIG) + 1; j++) begin
            @(negedge clk);
            check("busy", {31'b0, busy}, {31'b0, (j <= int'(NDIG))});
            check("done", {31'b0, done}, {31'b0, (j == int'(NDIG) + 1)});
            if (j <= int'(NDIG)) check("sum_hold", 32'(sum), 32'(prev_sum));
            start  = (noise && j == 2 && NDIG >= 3);
            a_in   = W'($urandom);
            b_in   = W'($urandom);
            cin_in = 1'($urandom);
        end
        check("sum", 32'(sum), 32'(es));
        check("cout", {31'b0, cout}, {31'b0, ec});
        check("err", {31'b0, err}, {31'b0, ee});
        prev_sum = es;
    endtask

    task automatic run_rand();
        logic [W-1:0] a, b;
        logic         cin;
        int unsigned  tot;
        a   = rand_bcd();
        b   = rand_bcd();
        cin = 1'($urandom);
        tot = bcd2int(a) + bcd2int(b) + cin;
        run_op(a, b, cin, int2bcd(tot % pow10n()), (tot >= pow10n()), 1'b0, bit'($urandom));
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        cin_in = 1'b0;
        prev_sum = '0;
        #12;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", {31'b0, cout}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0);
        run_op(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
        run_op(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b1);
        run_op(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b0);

        // start held high: one result per NDIG+1 cycles
        start  = 1'b1;
        a_in   = 16'h0500;
        b_in   = 16'h0500;
        cin_in = 1'b0;
        @(posedge clk);
        for (int j = 1; j <= 3 * (int'(NDIG) + 1); j++) begin
            @(negedge clk);
            check("b2b_done", {31'b0, done}, {31'b0, (j % (int'(NDIG) + 1) == 0)});
            check("b2b_busy", {31'b0, busy}, {31'b0, (j % (int'(NDIG) + 1) != 0)});
            if (j % (int'(NDIG) + 1) == 0) check("b2b_sum", 32'(sum), 32'h1000);
            if (j == 3 * (int'(NDIG) + 1)) start = 1'b0;
        end
        prev_sum = 16'h1000;
        @(negedge clk);

        // abort in the second RUN cycle
        start  = 1'b1;
        a_in   = 16'h1111;
        b_in   = 16'h2222;
        cin_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", {31'b0, cout}, 32'd0);
        check("abort_err", {31'b0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < int'(NDIG) + 2; j++) begin
            @(negedge clk);
            check("abort_nodone", {31'b0, done}, 32'd0);
            check("abort_idle", {31'b0, busy}, 32'd0);
        end
        prev_sum = '0;
        run_op(16'h0042, 16'h0058, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);

        // invalid digit: sum still follows the digit rule
        run_op(16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, ErrEn, 1'b0);
        run_op(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 25; k++) begin
            run_rand();
            if ($urandom_range(1, 0) == 1) @(negedge clk);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
